// File: rtl/dsp_mean_64to24.sv
// Block mean of ACC_LEN signed 64-bit scaled samples, rounded and saturated to 24 bits.
// Latency: result registered 1 cycle after the final sample; clk_enable low freezes all state.
module dsp_mean_64to24 #(
  parameter int ACC_LEN    = 16,
  parameter int FRAC_SHIFT = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic signed [63:0] in1,
  input  logic               in1_valid,
  output logic signed [23:0] out1,
  output logic               out1_valid,
  output logic               sat
);

  localparam int                 S    = $clog2(ACC_LEN) + FRAC_SHIFT;
  localparam logic [7:0]         LAST = 8'(ACC_LEN - 1);
  localparam logic signed [72:0] HALF = 73'sd1 <<< (S - 1);

  typedef enum logic {ACCUM, EMIT} state_t;

  state_t             state, state_nxt;
  logic signed [71:0] acc, acc_nxt, sum;
  logic [7:0]         count, count_nxt;
  logic signed [72:0] rnd, r;
  logic signed [23:0] out1_nxt;
  logic               sat_nxt;

  // One extra bit on the rounding add so the +half can never wrap at full scale.
  assign sum = acc + {{8{in1[63]}}, in1};
  assign rnd = {sum[71], sum} + HALF;
  assign r   = rnd >>> S;

  assign out1_valid = (state == EMIT);

  // EMIT lasts one enabled cycle; samples keep accumulating in both states.
  always_comb begin
    state_nxt = ACCUM;
    acc_nxt   = acc;
    count_nxt = count;
    out1_nxt  = out1;
    sat_nxt   = sat;
    if (in1_valid) begin
      if (count == LAST) begin
        acc_nxt   = '0;
        count_nxt = '0;
        state_nxt = EMIT;
        if (r > 73'sd8388607) begin
          out1_nxt = 24'sd8388607;
          sat_nxt  = 1'b1;
        end else if (r < -73'sd8388608) begin
          out1_nxt = 24'sh800000;
          sat_nxt  = 1'b1;
        end else begin
          out1_nxt = r[23:0];
          sat_nxt  = 1'b0;
        end
      end else begin
        acc_nxt   = sum;
        count_nxt = count + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
      out1  <= '0;
      sat   <= 1'b0;
    end else if (clk_enable) begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      out1  <= out1_nxt;
      sat   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_dsp_mean_64to24.sv
// Self-checking bench for dsp_mean_64to24 (ACC_LEN=4, FRAC_SHIFT=24) against a floor-division reference.
module tb_dsp_mean_64to24;

  logic               clk = 1'b0;
  logic               reset;
  logic               clk_enable;
  logic signed [63:0] in1;
  logic               in1_valid;
  logic signed [23:0] out1;
  logic               out1_valid;
  logic               sat;

  always #5 clk = ~clk;

  dsp_mean_64to24 #(.ACC_LEN(4), .FRAC_SHIFT(24)) dut (
    .clk        (clk),
    .reset      (reset),
    .clk_enable (clk_enable),
    .in1        (in1),
    .in1_valid  (in1_valid),
    .out1       (out1),
    .out1_valid (out1_valid),
    .sat        (sat)
  );

  typedef struct {
    logic signed [23:0] o;
    logic               s;
    int                 cyc;
  } strobe_t;

  strobe_t sq[$];
  int      cyc      = 0;
  int      n_checks = 0;
  int      n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // A strobe is one enabled cycle with out1_valid high.
  always @(negedge clk)
    if (!reset && clk_enable && out1_valid) sq.push_back('{out1, sat, cyc});

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Mean = floor((sum + 2^25) / 2^26), then clip to 24-bit signed.
  function automatic void ref_mean(input logic signed [63:0] a, input logic signed [63:0] b,
                                   input logic signed [63:0] c, input logic signed [63:0] d,
                                   output logic signed [23:0] o, output logic s);
    logic signed [79:0] tot, q;
    tot = a;
    tot = tot + b;
    tot = tot + c;
    tot = tot + d;
    tot = tot + 80'sd33554432;
    q = tot / 80'sd67108864;
    if (tot < 0 && q * 80'sd67108864 != tot) q = q - 80'sd1;
    if (q > 80'sd8388607) begin
      o = 24'sd8388607;  s = 1'b1;
    end else if (q < -80'sd8388608) begin
      o = 24'sh800000;   s = 1'b1;
    end else begin
      o = q[23:0];       s = 1'b0;
    end
  endfunction

  task automatic idle(input int n);
    clk_enable = 1'b1;
    in1_valid  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_blocks(input logic signed [63:0] smp[8], input int n, input bit gaps,
                             input string name);
    int                 acc_cyc[2];
    logic signed [23:0] eo;
    logic               es;
    eo = '0;
    es = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          if ($urandom_range(0, 1) == 0) begin
            in1_valid  = 1'b0;
            clk_enable = 1'($urandom_range(0, 1));
          end else begin
            in1_valid  = 1'b1;
            clk_enable = 1'b0;
          end
          in1 = {$urandom, $urandom};
          tick();
        end
      end
      clk_enable = 1'b1;
      in1_valid  = 1'b1;
      in1        = smp[i];
      tick();
      in1_valid  = 1'b0;
      if (i % 4 == 3) acc_cyc[i/4] = cyc;
    end
    if (gaps) begin
      clk_enable = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    idle(4);
    n_checks++;
    if (sq.size() != n / 4) begin
      n_fail++;
      $display("FAIL %s strobe_count: got %0d want %0d", name, sq.size(), n / 4);
    end
    for (int b = 0; b < n / 4 && b < sq.size(); b++) begin
      ref_mean(smp[4*b], smp[4*b+1], smp[4*b+2], smp[4*b+3], eo, es);
      n_checks++;
      if (sq[b].o !== eo) begin
        n_fail++;
        $display("FAIL %s out1[%0d]: got %0d want %0d", name, b, sq[b].o, eo);
      end
      n_checks++;
      if (sq[b].s !== es) begin
        n_fail++;
        $display("FAIL %s sat[%0d]: got %0b want %0b", name, b, sq[b].s, es);
      end
      if (!gaps) begin
        n_checks++;
        if (sq[b].cyc != acc_cyc[b]) begin
          n_fail++;
          $display("FAIL %s latency[%0d]: strobe cycle %0d want %0d", name, b, sq[b].cyc, acc_cyc[b]);
        end
      end
    end
    n_checks++;
    if (out1_valid !== 1'b0 || out1 !== eo || sat !== es) begin
      n_fail++;
      $display("FAIL %s hold: got out1=%0d sat=%0b vld=%0b want out1=%0d sat=%0b vld=0",
               name, out1, sat, out1_valid, eo, es);
    end
    sq.delete();
  endtask

  function automatic void fill(output logic signed [63:0] s[8], input logic signed [63:0] v);
    for (int i = 0; i < 8; i++) s[i] = v;
  endfunction

  task automatic test_reset();
    reset = 1'b1; clk_enable = 1'b0; in1_valid = 1'b1; in1 = 64'sd12345;
    tick(); tick();
    n_checks++;
    if (out1 !== 24'sd0 || out1_valid !== 1'b0 || sat !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got out1=%0d vld=%0b sat=%0b want 0 0 0", out1, out1_valid, sat);
    end
    reset = 1'b0; in1_valid = 1'b0;
    idle(2);
    sq.delete();
  endtask

  task automatic test_basic();
    logic signed [63:0] s[8];
    fill(s, 64'sd1 <<< 24);
    send_blocks(s, 4, 1'b0, "basic");
  endtask

  task automatic test_rounding();
    logic signed [63:0] s[8];
    fill(s, 64'sd0);
    s[0] = 64'sd1 <<< 25;
    send_blocks(s, 4, 1'b0, "round_pos_half");
    s[0] = -(64'sd1 <<< 25);
    send_blocks(s, 4, 1'b0, "round_neg_half");
    s[0] = -(64'sd1 <<< 25) - 64'sd1;
    send_blocks(s, 4, 1'b0, "round_below_half");
  endtask

  task automatic test_saturation();
    logic signed [63:0] s[8];
    fill(s, 64'sd1 <<< 62);
    send_blocks(s, 4, 1'b0, "sat_pos");
    fill(s, 64'sh8000_0000_0000_0000);
    send_blocks(s, 4, 1'b0, "sat_neg");
  endtask

  task automatic test_back_to_back();
    logic signed [63:0] s[8];
    fill(s, 64'sd3 <<< 24);
    send_blocks(s, 8, 1'b0, "back_to_back");
    send_blocks(s, 8, 1'b1, "gaps");
  endtask

  task automatic test_random();
    logic signed [63:0] s[8];
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 8; i++)
        s[i] = $signed({$urandom, $urandom}) >>> $urandom_range(0, 40);
      send_blocks(s, 8, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_enable_hold();
    for (int i = 0; i < 4; i++) begin
      clk_enable = 1'b1; in1_valid = 1'b1; in1 = 64'sd5 <<< 24;
      tick();
    end
    clk_enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in1 = {$urandom, $urandom};
      tick();
      n_checks++;
      if (out1_valid !== 1'b1 || out1 !== 24'sd5) begin
        n_fail++;
        $display("FAIL enable_hold[%0d]: got vld=%0b out1=%0d want vld=1 out1=5", k, out1_valid, out1);
      end
    end
    clk_enable = 1'b1; in1_valid = 1'b0;
    tick();
    n_checks++;
    if (out1_valid !== 1'b0 || sq.size() != 1) begin
      n_fail++;
      $display("FAIL enable_release: got vld=%0b strobes=%0d want vld=0 strobes=1", out1_valid, sq.size());
    end
    idle(2);
    sq.delete();
  endtask

  task automatic test_reset_mid_block();
    logic signed [63:0] s[8];
    for (int i = 0; i < 2; i++) begin
      clk_enable = 1'b1; in1_valid = 1'b1; in1 = 64'sd1 <<< 30;
      tick();
    end
    in1_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    fill(s, -(64'sd1 <<< 24));
    send_blocks(s, 4, 1'b0, "reset_mid_block");
  endtask

  task automatic test_reset_priority();
    logic signed [63:0] s[8];
    reset = 1'b1; clk_enable = 1'b1; in1_valid = 1'b1; in1 = 64'sd1 <<< 40;
    tick();
    reset = 1'b0; in1_valid = 1'b0;
    fill(s, 64'sd1 <<< 24);
    send_blocks(s, 4, 1'b0, "reset_priority");
  endtask

  initial begin
    reset = 1'b1; clk_enable = 1'b0; in1_valid = 1'b0; in1 = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_saturation();
    test_back_to_back();
    test_enable_hold();
    test_reset_mid_block();
    test_reset_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_mean_64to24.md
DSP_MEAN_64TO24 -- requirements
Module: dsp_mean_64to24

Interface
REQ-001 SHALL have parameter ACC_LEN, default 16, meaning samples per output block; power of two, 2..256.
REQ-002 SHALL have parameter FRAC_SHIFT, default 24, meaning fractional bits of in1 removed on output.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port clk_enable, input, 1; when low, all state holds and inputs are ignored.
REQ-006 SHALL have port in1, input, signed 64, sample in the 64-bit scaled format (40-bit value << 24).
REQ-007 SHALL have port in1_valid, input, 1; in1 is accepted on a cycle with in1_valid=1 and clk_enable=1.
REQ-008 SHALL have port out1, output, signed 24, rounded and saturated block mean.
REQ-009 SHALL have port out1_valid, output, 1, one-cycle strobe qualifying out1.
REQ-010 SHALL have port sat, output, 1, high with out1_valid when the result was clipped.

Function
REQ-011 SHALL keep a 72-bit signed accumulator (64 data + 8 guard bits) and an 8-bit sample counter; the sum SHALL never wrap internally.
REQ-012 SHALL use a two-state FSM: ACCUM (count accepted samples) and EMIT (register result); reset enters ACCUM with acc=0 and count=0.
REQ-013 In ACCUM, each accepted sample SHALL add sign-extended in1 to acc and increment count.
REQ-014 On acceptance of sample number ACC_LEN, the FSM SHALL form sum = acc + in1, clear acc and count in the same cycle, and go to EMIT.
REQ-015 Result SHALL be computed as: S = log2(ACC_LEN) + FRAC_SHIFT; r = (sum + 2^(S-1)) >>> S (round half toward +inf, arithmetic shift).
REQ-016 Clipping SHALL apply as follows: if r > 8388607, out1 = 8388607 and sat = 1; if r < -8388608, out1 = -8388608 and sat = 1; otherwise out1 = r[23:0] and sat = 0.
REQ-017 out1, sat and out1_valid SHALL be registered; out1_valid SHALL rise on the clock edge after the final sample's acceptance edge, a latency of 1 cycle.
REQ-018 In EMIT, out1_valid SHALL be 1 for exactly one enabled cycle, then the FSM returns to ACCUM.
REQ-019 A sample arriving while in EMIT SHALL be accepted as sample 1 of the next block, so back-to-back streaming loses no data.
REQ-020 out1 and sat SHALL hold their last value until the next block completes; out1_valid SHALL be 0 otherwise.
REQ-021 Gaps in in1_valid SHALL not affect the result; only accepted samples count.
REQ-022 With clk_enable=0, the FSM, acc, count and outputs SHALL hold; an out1_valid already high SHALL stay high until the next enabled cycle.

Reset
REQ-023 While reset=1 at a clock edge, the block SHALL set acc=0, count=0, FSM=ACCUM, out1=0, out1_valid=0 and sat=0, regardless of clk_enable.
REQ-024 Reset mid-block SHALL discard the partial sum; the first accepted sample after reset SHALL be sample 1.
REQ-025 Reset in the same cycle as a valid input SHALL take priority; that sample SHALL be dropped.

Verification (ACC_LEN=4, FRAC_SHIFT=24, so S=26)
REQ-026 Basic: 4 consecutive samples of 2^24 SHALL produce out1=1, sat=0 and out1_valid for exactly one cycle, 1 cycle after the 4th sample.
REQ-027 Rounding: samples {2^25, 0, 0, 0} SHALL give out1=1; samples {-2^25, 0, 0, 0} SHALL give out1=0; samples {-2^25-1, 0, 0, 0} SHALL give out1=-1.
REQ-028 Saturation: 4 samples of 2^62 SHALL give out1=8388607 and sat=1; 4 samples of -2^63 SHALL give out1=-8388608 and sat=1.
REQ-029 Streaming and gaps:
- 8 back-to-back samples of 3*2^24 SHALL give two strobes, each with out1=3.
- The same 8 samples with random in1_valid gaps and clk_enable low cycles SHALL give identical results.
REQ-030 Reset mid-block: 2 samples of 2^30, then reset, then 4 samples of -2^24 SHALL give a single strobe with out1=-1.
